// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI encodings and request bookkeeping for the SRAM responder.
package axi_sram_slave_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = 8;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Address-phase fields kept for the life of one burst.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_req_t;

  // Whole-burst rejection: beats wider than the bus, or WRAP bursts.
  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'd3) || (burst == BURST_WRAP);
  endfunction

  // Address of the following beat; FIXED bursts stay on one address.
  function automatic logic [AXI_ADDR_W-1:0] next_beat_addr(input axi_req_t req);
    if (req.burst == BURST_FIXED) return req.addr;
    return req.addr + (32'd1 << req.size);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus without ID signals, 32-bit address, 64-bit data.
interface axi;
  import axi_sram_slave_pkg::*;

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave_no_id (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bresp, bvalid, arready,
    output rdata, rresp, rlast, rvalid
  );

  modport master_no_id (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bresp, bvalid, arready,
    input  rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/sram_1rw_be.sv
// Single-port synchronous 64-bit RAM with byte-enable writes.
// The read register only updates on an enabled read, so it holds otherwise.
module sram_1rw_be #(
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            be,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem [2**DEPTH_LOG2];

  // Byte-masked write or registered read, one access per cycle.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 (no-ID) responder over a 64-bit on-chip SRAM, one transaction at a time.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic       clock,
  input  logic       reset,
  axi.slave_no_id    axi_bus
);

  typedef enum logic [1:0] {S_IDLE, S_RDATA, S_WDATA, S_WRESP} state_t;

  // Beat is outside the SRAM window (below base or past the last word).
  function automatic logic out_of_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a < BASE_ADDR) || ((off >> 3) >= (32'd1 << DEPTH_LOG2));
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 3);
  endfunction

  state_t   state_q, state_d;
  axi_req_t req_q;
  logic [7:0] cnt_q;
  logic     burst_err_q;
  logic     last_grant_q;   // 1: write was granted last
  logic     rvalid_q, rerr_q, rlast_q;
  logic     bvalid_q, berr_q;

  logic        ar_grant, aw_grant;
  logic        r_fire, r_final, rd_next;
  logic        w_fire, w_final, w_beat_err, wlast_bad;
  logic        b_fire;
  logic [31:0] next_addr;
  logic        sram_en, sram_we;
  logic [DEPTH_LOG2-1:0] sram_addr;
  logic [63:0] sram_q;

  // On a tie the channel not granted last time wins.
  assign ar_grant = (state_q == S_IDLE) && axi_bus.arvalid && (!axi_bus.awvalid || last_grant_q);
  assign aw_grant = (state_q == S_IDLE) && axi_bus.awvalid && (!axi_bus.arvalid || !last_grant_q);

  assign next_addr  = next_beat_addr(req_q);
  assign r_fire     = rvalid_q && axi_bus.rready;
  assign r_final    = r_fire && rlast_q;
  assign rd_next    = r_fire && !rlast_q;
  assign w_fire     = (state_q == S_WDATA) && axi_bus.wvalid;
  assign w_final    = w_fire && (cnt_q == req_q.len);
  assign w_beat_err = burst_err_q || out_of_range(req_q.addr);
  assign wlast_bad  = axi_bus.wlast != (cnt_q == req_q.len);
  assign b_fire     = bvalid_q && axi_bus.bready;

  // The SRAM is only enabled to issue a new read beat or commit a clean write beat.
  assign sram_en   = ar_grant || rd_next || (w_fire && !w_beat_err);
  assign sram_we   = w_fire;
  assign sram_addr = ar_grant ? word_idx(axi_bus.araddr) :
                     rd_next  ? word_idx(next_addr) : word_idx(req_q.addr);

  sram_1rw_be #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clock (clock),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .be    (axi_bus.wstrb),
    .wdata (axi_bus.wdata),
    .rdata (sram_q)
  );

  assign axi_bus.arready = ar_grant;
  assign axi_bus.awready = aw_grant;
  assign axi_bus.wready  = (state_q == S_WDATA);
  assign axi_bus.rvalid  = rvalid_q;
  assign axi_bus.rdata   = (rvalid_q && !rerr_q) ? sram_q : 64'd0;
  assign axi_bus.rresp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
  assign axi_bus.rlast   = rlast_q;
  assign axi_bus.bvalid  = bvalid_q;
  assign axi_bus.bresp   = berr_q ? RESP_SLVERR : RESP_OKAY;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Transaction sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ar_grant)      state_d = S_RDATA;
        else if (aw_grant) state_d = S_WDATA;
      end
      S_RDATA: if (r_final) state_d = S_IDLE;
      S_WDATA: if (w_final) state_d = S_WRESP;
      S_WRESP: if (b_fire)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat counter, grant history, response flags and handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      burst_err_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rerr_q       <= 1'b0;
      rlast_q      <= 1'b0;
      bvalid_q     <= 1'b0;
      berr_q       <= 1'b0;
    end else begin
      if (ar_grant) begin
        last_grant_q <= 1'b0;
        cnt_q        <= '0;
        burst_err_q  <= burst_bad(axi_bus.arsize, axi_bus.arburst);
        rvalid_q     <= 1'b1;
        rerr_q       <= burst_bad(axi_bus.arsize, axi_bus.arburst) || out_of_range(axi_bus.araddr);
        rlast_q      <= (axi_bus.arlen == 8'd0);
      end else if (rd_next) begin
        cnt_q   <= cnt_q + 8'd1;
        rerr_q  <= burst_err_q || out_of_range(next_addr);
        rlast_q <= ((cnt_q + 8'd1) == req_q.len);
      end else if (r_final) begin
        rvalid_q <= 1'b0;
        rerr_q   <= 1'b0;
        rlast_q  <= 1'b0;
      end
      if (aw_grant) begin
        last_grant_q <= 1'b1;
        cnt_q        <= '0;
        burst_err_q  <= burst_bad(axi_bus.awsize, axi_bus.awburst);
        berr_q       <= 1'b0;
      end
      if (w_fire) begin
        cnt_q  <= cnt_q + 8'd1;
        berr_q <= berr_q || w_beat_err || wlast_bad;
      end
      if (w_final)     bvalid_q <= 1'b1;
      else if (b_fire) bvalid_q <= 1'b0;
    end
  end

  // Latched request; address advances after every accepted beat.
  always_ff @(posedge clock) begin
    if (ar_grant)
      req_q <= '{addr: axi_bus.araddr, len: axi_bus.arlen, size: axi_bus.arsize, burst: axi_bus.arburst};
    else if (aw_grant)
      req_q <= '{addr: axi_bus.awaddr, len: axi_bus.awlen, size: axi_bus.awsize, burst: axi_bus.awburst};
    else if (rd_next || w_fire)
      req_q.addr <= next_addr;
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with hand-computed expected values.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [63:0] wdat [0:7];
  logic [63:0] rexp [0:7];

  localparam logic [63:0] D0 = 64'h0001_0203_0405_0607;
  localparam logic [63:0] D1 = 64'h1011_1213_1415_1617;
  localparam logic [63:0] D2 = 64'h2021_2223_2425_2627;
  localparam logic [63:0] D3 = 64'h3031_3233_3435_3637;
  localparam logic [63:0] DX = 64'hCAFE_F00D_0BAD_BEEF;

  axi bus();

  axi_sram_slave #(.DEPTH_LOG2(13), .BASE_ADDR(32'h8000_0000)) dut (
    .clock   (clock),
    .reset   (reset),
    .axi_bus (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Wait (sampling on the falling edge) until the chosen signal is high.
  task automatic wait_hi(input int which, input string tag);
    int   g;
    logic s;
    g = 0;
    s = 1'b0;
    while (g < 50) begin
      @(negedge clock);
      case (which)
        0:       s = bus.awready;
        1:       s = bus.wready;
        2:       s = bus.bvalid;
        3:       s = bus.arready;
        default: s = bus.rvalid;
      endcase
      if (s) break;
      g++;
    end
    if (!s) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] strb, input bit bad_last,
                          output logic [1:0] resp);
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
    wait_hi(0, "aw");
    @(posedge clock); #1 bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.wdata = wdat[b]; bus.wstrb = strb;
      bus.wlast = bad_last ? (b == 0) : (b == int'(len));
      bus.wvalid = 1'b1;
      wait_hi(1, "w");
      @(posedge clock); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    wait_hi(2, "b");
    resp = bus.bresp;
    @(posedge clock); #1 bus.bready = 1'b0;
  endtask

  // Read a burst, checking every cycle that rvalid is high against rexp[beat].
  task automatic do_read(input string tag, input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input bit toggle, input logic [1:0] exp_resp,
                         output int lat);
    int   beat, guard, prev;
    logic ar_hs, r_hs;
    beat = 0; guard = 0; prev = 0; lat = -1;
    bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (beat <= len && guard < 200) begin
      @(negedge clock);
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      if (bus.rvalid) begin
        chk({tag, "_rdata"}, bus.rdata, rexp[beat]);
        chk({tag, "_rresp"}, 64'(bus.rresp), 64'(exp_resp));
        chk({tag, "_rlast"}, 64'(bus.rlast), 64'(beat == len));
      end
      @(posedge clock); #1;
      guard++;
      if (ar_hs) bus.arvalid = 1'b0;
      if (r_hs) begin
        if (beat == 0) lat = guard;
        else if (!toggle) chk({tag, "_gap"}, 64'(guard - prev), 64'd1);
        prev = guard;
        beat++;
      end
      if (toggle) bus.rready = ~bus.rready;
    end
    if (beat <= len) chk({tag, "_timeout"}, 64'(beat), 64'(len + 1));
    bus.rready = 1'b0; bus.arvalid = 1'b0;
  endtask

  initial begin
    logic [1:0] resp;
    int lat;
    vectors = 0; miscompares = 0;
    clock = 1'b0; reset = 1'b1;
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("rst_rdata",   bus.rdata,        64'd0);
    chk("rst_rresp",   64'(bus.rresp),   64'(RESP_OKAY));
    chk("rst_bresp",   64'(bus.bresp),   64'(RESP_OKAY));
    chk("rst_rlast",   64'(bus.rlast),   64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // INCR write burst to words 0..3, then stream and stalled reads.
    wdat[0] = D0; wdat[1] = D1; wdat[2] = D2; wdat[3] = D3;
    do_write(32'h8000_0000, 8'd3, 3'd3, BURST_INCR, 8'hFF, 1'b0, resp);
    chk("burst_wr_bresp", 64'(resp), 64'(RESP_OKAY));
    rexp[0] = D0; rexp[1] = D1; rexp[2] = D2; rexp[3] = D3;
    do_read("incr_rd", 32'h8000_0000, 3, 3'd3, BURST_INCR, 1'b0, RESP_OKAY, lat);
    chk("incr_rd_lat", 64'(lat), 64'd2);
    do_read("incr_stall", 32'h8000_0000, 3, 3'd3, BURST_INCR, 1'b1, RESP_OKAY, lat);

    // Single write then read.
    wdat[0] = 64'h1122_3344_5566_7788;
    do_write(32'h8000_0010, 8'd0, 3'd3, BURST_INCR, 8'hFF, 1'b0, resp);
    chk("single_bresp", 64'(resp), 64'(RESP_OKAY));
    rexp[0] = 64'h1122_3344_5566_7788;
    do_read("single_rd", 32'h8000_0010, 0, 3'd3, BURST_INCR, 1'b0, RESP_OKAY, lat);
    chk("single_rd_lat", 64'(lat), 64'd2);

    // Byte strobe on lane 2 only.
    wdat[0] = 64'h0000_0000_00AB_0000;
    do_write(32'h8000_0010, 8'd0, 3'd0, BURST_INCR, 8'h04, 1'b0, resp);
    chk("strb_bresp", 64'(resp), 64'(RESP_OKAY));
    rexp[0] = 64'h1122_3344_55AB_7788;
    do_read("strb_rd", 32'h8000_0010, 0, 3'd3, BURST_INCR, 1'b0, RESP_OKAY, lat);

    // Out of range: below base and one past the end (which would alias word 0).
    rexp[0] = 64'd0;
    do_read("oor_rd", 32'h7FFF_FFF8, 0, 3'd3, BURST_INCR, 1'b0, RESP_SLVERR, lat);
    wdat[0] = 64'hDEAD_DEAD_DEAD_DEAD;
    do_write(32'h8001_0000, 8'd0, 3'd3, BURST_INCR, 8'hFF, 1'b0, resp);
    chk("oor_bresp", 64'(resp), 64'(RESP_SLVERR));
    rexp[0] = D0;
    do_read("oor_unchanged", 32'h8000_0000, 0, 3'd3, BURST_INCR, 1'b0, RESP_OKAY, lat);

    // WRAP read burst is refused beat by beat; wlast early/missing gives SLVERR.
    rexp[0] = 64'd0; rexp[1] = 64'd0;
    do_read("wrap_rd", 32'h8000_0000, 1, 3'd3, BURST_WRAP, 1'b0, RESP_SLVERR, lat);
    wdat[0] = D2; wdat[1] = D3;
    do_write(32'h8000_0030, 8'd1, 3'd3, BURST_INCR, 8'hFF, 1'b1, resp);
    chk("wlast_bresp", 64'(resp), 64'(RESP_SLVERR));

    // Reset pulse so the tie-break starts from "write granted last".
    reset = 1'b1; @(posedge clock); @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    bus.araddr = 32'h8000_0000; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    bus.awaddr = 32'h8000_0020; bus.awlen = 8'd0; bus.awsize = 3'd3; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    @(negedge clock);
    chk("tie1_arready", 64'(bus.arready), 64'd1);
    chk("tie1_awready", 64'(bus.awready), 64'd0);
    @(posedge clock); #1 bus.arvalid = 1'b0; bus.rready = 1'b1;
    wait_hi(4, "tie1_r");
    chk("tie1_rdata", bus.rdata, D0);
    chk("tie1_rlast", 64'(bus.rlast), 64'd1);
    @(posedge clock); #1 bus.rready = 1'b0;
    bus.araddr = 32'h8000_0020; bus.arvalid = 1'b1;
    @(negedge clock);
    chk("tie2_awready", 64'(bus.awready), 64'd1);
    chk("tie2_arready", 64'(bus.arready), 64'd0);
    @(posedge clock); #1 bus.awvalid = 1'b0;
    bus.wdata = DX; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    wait_hi(1, "tie2_w");
    @(posedge clock); #1 bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    wait_hi(2, "tie2_b");
    chk("tie2_bresp", 64'(bus.bresp), 64'(RESP_OKAY));
    @(posedge clock); #1 bus.bready = 1'b0;
    wait_hi(3, "tie2_ar");
    @(posedge clock); #1 bus.arvalid = 1'b0; bus.rready = 1'b1;
    wait_hi(4, "tie2_r");
    chk("tie2_rdata", bus.rdata, DX);
    chk("tie2_rresp", 64'(bus.rresp), 64'(RESP_OKAY));
    @(posedge clock); #1 bus.rready = 1'b0;

    // Reset in the middle of a len=7 write burst.
    bus.awaddr = 32'h8000_0100; bus.awlen = 8'd7; bus.awsize = 3'd3; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    wait_hi(0, "mid_aw");
    @(posedge clock); #1 bus.awvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.wdata = 64'(b); bus.wstrb = 8'hFF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      wait_hi(1, "mid_w");
      @(posedge clock); #1;
    end
    chk("mid_wready_pre", 64'(bus.wready), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_wready", 64'(bus.wready), 64'd0);
    chk("mid_bvalid", 64'(bus.bvalid), 64'd0);
    chk("mid_awready", 64'(bus.awready), 64'd0);
    bus.wvalid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    rexp[0] = 64'h1122_3344_55AB_7788;
    do_read("post_rst_rd", 32'h8000_0010, 0, 3'd3, BURST_INCR, 1'b0, RESP_OKAY, lat);
    chk("post_rst_lat", 64'(lat), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
